// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select of a shared 4:1 mux.
// A granted source keeps the mux until it drops its request, or until it has
// held it for MAX_HOLD cycles while somebody else waits, at which point the
// grant is rotated to the next requester and a one-cycle preempt pulse is
// raised. All outputs come straight from registers.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              preempt_q, preempt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Requests that compete for the next grant. While someone owns the mux the
  // owner is masked out, so a rotation can never hand the mux back to it.
  logic [3:0] arb_req;
  logic       others_pending;
  logic       owner_req;
  logic       win_found;
  logic [1:0] win_idx;
  logic [3:0] win_onehot;

  // Build the competing request vector and the "someone else is waiting" flag.
  always_comb begin
    arb_req        = (state_q == GRANT) ? (req & ~grant_q) : req;
    others_pending = |(req & ~grant_q);
    owner_req      = req[sel_q];
  end

  // Rotating priority scan: first requester at or after ptr (mod 4) wins.
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_found && arb_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    win_onehot = 4'b0001 << win_idx;
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          grant_d    = win_onehot;
          sel_d      = win_idx;
          ptr_d      = win_idx + 2'd1;
          hold_cnt_d = '0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Owner released: hand over directly, no idle bubble, if anyone waits.
          if (win_found) begin
            grant_d    = win_onehot;
            sel_d      = win_idx;
            ptr_d      = win_idx + 2'd1;
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            grant_d    = 4'b0000;
            hold_cnt_d = '0;
          end
        end else if (others_pending) begin
          if (hold_cnt_q == HOLD_LAST) begin
            // Hold budget exhausted while others wait: forcibly rotate.
            grant_d    = win_onehot;
            sel_d      = win_idx;
            ptr_d      = win_idx + 2'd1;
            hold_cnt_d = '0;
            preempt_d  = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end else begin
          // A lone owner is never preempted; its budget restarts.
          hold_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase

    gnt_valid_d = (grant_d != 4'b0000);
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 4'b0000;
      sel_q       <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter (MAX_HOLD=4): table of directed vectors plus
// hand-written sequences for long holds, full rotation and mid-grant reset.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       gnt_valid;
  logic       preempt;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       preempt;
  } vec_t;

  vec_t vecs[$];

  mux4_rr_arbiter #(
    .MAX_HOLD(4),
    .HOLD_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic ev, input logic ep);
    check({tag, ".grant"},   grant,            eg);
    check({tag, ".sel"},     {2'b00, sel},     {2'b00, es});
    check({tag, ".valid"},   {3'b000, gnt_valid}, {3'b000, ev});
    check({tag, ".preempt"}, {3'b000, preempt},   {3'b000, ep});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic p);
    vec_t t;
    t.req = r; t.grant = g; t.sel = s; t.valid = v; t.preempt = p;
    vecs.push_back(t);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;

    // Idle after reset
    for (int i = 0; i < 5; i++) add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Two requesters: 0 wins from ptr=0, then release hands over to 2 with no bubble
    for (int i = 0; i < 3; i++) add(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    // ptr=3 scan wraps to 1; then owner drops while 3 raises in the same edge
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);

    // Reset asserted across two edges, released just after an edge
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req = vecs[i].req;
      step();
      $display("vec %0d req=%b grant=%b sel=%0d valid=%b preempt=%b",
               i, req, grant, sel, gnt_valid, preempt);
      check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid, vecs[i].preempt);
    end

    // Lone owner held 20 more cycles: never preempted
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      step();
      $display("lone %0d grant=%b preempt=%b", c, grant, preempt);
      check_all($sformatf("lone%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    $display("lone_end grant=%b sel=%0d", grant, sel);
    check_all("lone_end", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Full contention: each source held 4 cycles, preempt on every rotation
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      logic [1:0] own;
      own = 2'((c / 4) % 4);
      step();
      $display("rot %0d grant=%b sel=%0d preempt=%b", c, grant, sel, preempt);
      check_all($sformatf("rot%0d", c), 4'b0001 << own, own, 1'b1,
                ((c % 4) == 0) && (c > 0));
    end
    req = 4'b0000;
    step();
    $display("rot_end grant=%b sel=%0d", grant, sel);
    check_all("rot_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Mid-grant asynchronous reset, then restart from ptr=0
    req = 4'b0100;
    step();
    $display("pre_rst grant=%b sel=%0d", grant, sel);
    check_all("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    $display("async_rst grant=%b sel=%0d valid=%b", grant, sel, gnt_valid);
    check_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1010;
    #2 rst_n = 1'b1;
    step();
    $display("post_rst grant=%b sel=%0d", grant, sel);
    check_all("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
